// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared widths and result-entry type for the GPR write-back arbiter
//
// Purpose: default data/address widths, register count and the {rd, data}
// result entry carried through the mul/div result buffer.
// Ports: none (package).

package wb_arbiter_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 5;
    localparam int NUM_GPR   = 32;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

    localparam int WB_ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/wb_arbiter_fifo.sv
// rtl/wb_arbiter_fifo.sv - synchronous FIFO buffering mul/div results awaiting write-back
//
// Purpose: small power-of-2 FIFO with first-word-fall-through head.
// Ports:
//   clk, reset          clock, synchronous active-low reset (empties the FIFO)
//   push, push_entry    write an entry (caller guarantees !full)
//   pop                 drop the head entry (caller guarantees !empty)
//   full, empty         occupancy flags
//   head                oldest entry, valid while !empty

module wb_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_entry,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Storage is not reset: pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - GPR write-port arbiter merging pipeline and mul/div results
//
// Purpose: sole driver of the register-file write port. The in-order pipeline
// has priority; mul/div results queue in wb_fifo and get a forced slot after
// STARVE_MAX consecutive pipeline wins. Tracks GPRs awaiting mul/div results.
// Ports:
//   clk, reset                        clock, synchronous active-low reset
//   pipe_we, pipe_rd, pipe_data       pipeline result
//   pipe_stall                        pipeline must hold its result this cycle
//   md_issue, md_issue_rd             mul/div issue (marks destination busy)
//   md_valid, md_rd, md_data, md_ready  mul/div result handshake
//   regwrite, rd, writedata           registered register-file write port
//   busy                              per-GPR pending mul/div scoreboard
//   issue_conflict                    pulse: issue to an already busy GPR

module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DATA_W     = WB_DATA_W,
    parameter int ADDR_W     = WB_ADDR_W,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pipe_we,
    input  logic [ADDR_W-1:0]    pipe_rd,
    input  logic [DATA_W-1:0]    pipe_data,
    output logic                 pipe_stall,
    input  logic                 md_issue,
    input  logic [ADDR_W-1:0]    md_issue_rd,
    input  logic                 md_valid,
    input  logic [ADDR_W-1:0]    md_rd,
    input  logic [DATA_W-1:0]    md_data,
    output logic                 md_ready,
    output logic                 regwrite,
    output logic [ADDR_W-1:0]    rd,
    output logic [DATA_W-1:0]    writedata,
    output logic [2**ADDR_W-1:0] busy,
    output logic                 issue_conflict
);

    localparam int EW = ADDR_W + DATA_W;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    logic              fifo_full;
    logic              fifo_empty;
    logic [EW-1:0]     fifo_head;
    logic              fifo_push;
    logic              fifo_pop;
    logic [ADDR_W-1:0] head_rd;
    logic [DATA_W-1:0] head_data;

    logic [SW-1:0]        starve;
    logic [SW-1:0]        starve_n;
    logic                 sel_we;
    logic [ADDR_W-1:0]    sel_rd;
    logic [DATA_W-1:0]    sel_data;
    logic                 pipe_valid;
    logic [2**ADDR_W-1:0] busy_n;

    assign md_ready   = !fifo_full;
    assign fifo_push  = md_valid && !fifo_full;
    assign head_rd    = fifo_head[EW-1:DATA_W];
    assign head_data  = fifo_head[DATA_W-1:0];
    // A pipeline write to r0 is indistinguishable from an idle pipeline.
    assign pipe_valid = pipe_we && (pipe_rd != '0);
    assign pipe_stall = !fifo_empty && (starve == SMAX);

    wb_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (fifo_push),
        .push_entry ({md_rd, md_data}),
        .pop        (fifo_pop),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head       (fifo_head)
    );

    always_comb begin
        sel_we   = 1'b0;
        sel_rd   = head_rd;
        sel_data = head_data;
        fifo_pop = 1'b0;
        starve_n = '0;
        if (pipe_stall) begin
            fifo_pop = 1'b1;
            sel_we   = (head_rd != '0);
        end else if (pipe_valid) begin
            sel_we   = 1'b1;
            sel_rd   = pipe_rd;
            sel_data = pipe_data;
            // Only pipeline wins over a waiting mul/div result count as starvation.
            if (!fifo_empty) begin
                starve_n = (starve == SMAX) ? starve : starve + SW'(1);
            end
        end else if (!fifo_empty) begin
            fifo_pop = 1'b1;
            sel_we   = (head_rd != '0);
        end
    end

    // Clear on pop first so a same-cycle issue to the same register wins.
    always_comb begin
        busy_n = busy;
        if (fifo_pop && (head_rd != '0)) begin
            busy_n[head_rd] = 1'b0;
        end
        if (md_issue && (md_issue_rd != '0)) begin
            busy_n[md_issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            regwrite       <= 1'b0;
            rd             <= '0;
            writedata      <= '0;
            busy           <= '0;
            issue_conflict <= 1'b0;
            starve         <= '0;
        end else begin
            regwrite <= sel_we;
            if (sel_we) begin
                rd        <= sel_rd;
                writedata <= sel_data;
            end
            busy           <= busy_n;
            issue_conflict <= md_issue && (md_issue_rd != '0) && busy[md_issue_rd];
            starve         <= starve_n;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed self-checking bench for wb_arbiter

module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_we;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        pipe_stall;
    logic        md_issue;
    logic [4:0]  md_issue_rd;
    logic        md_valid;
    logic [4:0]  md_rd;
    logic [31:0] md_data;
    logic        md_ready;
    logic        regwrite;
    logic [4:0]  rd;
    logic [31:0] writedata;
    logic [31:0] busy;
    logic        issue_conflict;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_arbiter #(
        .DATA_W     (32),
        .ADDR_W     (5),
        .FIFO_DEPTH (2),
        .STARVE_MAX (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .pipe_we        (pipe_we),
        .pipe_rd        (pipe_rd),
        .pipe_data      (pipe_data),
        .pipe_stall     (pipe_stall),
        .md_issue       (md_issue),
        .md_issue_rd    (md_issue_rd),
        .md_valid       (md_valid),
        .md_rd          (md_rd),
        .md_data        (md_data),
        .md_ready       (md_ready),
        .regwrite       (regwrite),
        .rd             (rd),
        .writedata      (writedata),
        .busy           (busy),
        .issue_conflict (issue_conflict)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input logic exp_we, input logic [4:0] exp_rd,
                          input logic [31:0] exp_data);
        chk({tag, ".regwrite"}, 64'(regwrite), 64'(exp_we));
        chk({tag, ".rd"}, 64'(rd), 64'(exp_rd));
        chk({tag, ".writedata"}, 64'(writedata), 64'(exp_data));
    endtask

    initial begin
        reset       = 1'b0;
        pipe_we     = 1'b0;
        pipe_rd     = '0;
        pipe_data   = '0;
        md_issue    = 1'b0;
        md_issue_rd = '0;
        md_valid    = 1'b1;
        md_rd       = 5'd3;
        md_data     = 32'hAAAA_0001;

        // 1: reset held two cycles with md_valid high
        tick();
        tick();
        chk_wr("rst", 1'b0, 5'd0, 32'h0);
        chk("rst.busy", 64'(busy), 64'h0);
        chk("rst.md_ready", 64'(md_ready), 64'h1);
        chk("rst.pipe_stall", 64'(pipe_stall), 64'h0);
        chk("rst.conflict", 64'(issue_conflict), 64'h0);
        md_valid = 1'b0;
        reset    = 1'b1;
        tick();
        chk("rst.no_ghost", 64'(regwrite), 64'h0);

        // 2: single pipeline write, then idle holds rd/writedata
        pipe_we   = 1'b1;
        pipe_rd   = 5'd5;
        pipe_data = 32'hDEAD_BEEF;
        tick();
        chk_wr("pipe1", 1'b1, 5'd5, 32'hDEAD_BEEF);
        pipe_we = 1'b0;
        tick();
        chk_wr("pipe1.idle", 1'b0, 5'd5, 32'hDEAD_BEEF);

        // 3: mul/div issue, later result, 2-cycle latency, busy lifetime
        md_issue    = 1'b1;
        md_issue_rd = 5'd7;
        tick();
        md_issue = 1'b0;
        chk("md.busy_set", 64'(busy), 64'h80);
        tick();
        tick();
        md_valid = 1'b1;
        md_rd    = 5'd7;
        md_data  = 32'h1234_5678;
        tick();
        md_valid = 1'b0;
        chk("md.busy_held", 64'(busy), 64'h80);
        chk("md.not_yet", 64'(regwrite), 64'h0);
        tick();
        chk_wr("md.write", 1'b1, 5'd7, 32'h1234_5678);
        chk("md.busy_clr", 64'(busy), 64'h0);

        // 4: starvation: four pipeline wins then one forced FIFO slot
        pipe_we   = 1'b1;
        pipe_rd   = 5'd3;
        pipe_data = 32'hA0;
        md_valid  = 1'b1;
        md_rd     = 5'd9;
        md_data   = 32'h99;
        tick();
        md_valid = 1'b0;
        chk_wr("starve.p0", 1'b1, 5'd3, 32'hA0);
        chk("starve.stall0", 64'(pipe_stall), 64'h0);
        for (int i = 1; i <= 4; i++) begin
            pipe_data = 32'hA0 + 32'(i);
            tick();
            chk_wr("starve.pi", 1'b1, 5'd3, 32'hA0 + 32'(i));
            chk("starve.stall", 64'(pipe_stall), (i == 4) ? 64'h1 : 64'h0);
        end
        pipe_data = 32'hA5;
        tick();
        chk_wr("starve.forced", 1'b1, 5'd9, 32'h99);
        chk("starve.release", 64'(pipe_stall), 64'h0);
        tick();
        chk_wr("starve.resume", 1'b1, 5'd3, 32'hA5);

        // 5: fill FIFO behind a busy pipeline, drain with r0 traffic on both sides
        md_valid = 1'b1;
        md_rd    = 5'd10;
        md_data  = 32'h1;
        tick();
        chk("full.ready1", 64'(md_ready), 64'h1);
        md_rd   = 5'd11;
        md_data = 32'h2;
        tick();
        chk("full.ready0", 64'(md_ready), 64'h0);
        pipe_rd   = 5'd0;
        pipe_data = 32'hBAD0;
        md_rd     = 5'd0;
        md_data   = 32'h55;
        tick();
        chk_wr("full.pop10", 1'b1, 5'd10, 32'h1);
        chk("full.ready_after_pop", 64'(md_ready), 64'h1);
        tick();
        md_valid = 1'b0;
        chk_wr("full.pop11", 1'b1, 5'd11, 32'h2);
        chk("full.pushpop_cnt", 64'(md_ready), 64'h1);
        tick();
        chk_wr("full.r0_drop", 1'b0, 5'd11, 32'h2);
        tick();
        chk_wr("full.empty", 1'b0, 5'd11, 32'h2);
        pipe_we = 1'b0;

        // 6: double issue -> one-cycle conflict pulse
        md_issue    = 1'b1;
        md_issue_rd = 5'd4;
        tick();
        chk("conf.none", 64'(issue_conflict), 64'h0);
        chk("conf.busy", 64'(busy), 64'h10);
        tick();
        md_issue = 1'b0;
        chk("conf.pulse", 64'(issue_conflict), 64'h1);
        chk("conf.busy_kept", 64'(busy), 64'h10);
        tick();
        chk("conf.pulse_end", 64'(issue_conflict), 64'h0);

        // 6b: reset in the middle of a FIFO drain
        pipe_we   = 1'b1;
        pipe_rd   = 5'd3;
        pipe_data = 32'hC0;
        md_valid  = 1'b1;
        md_rd     = 5'd20;
        md_data   = 32'hE0;
        tick();
        md_rd   = 5'd21;
        md_data = 32'hE1;
        tick();
        md_valid = 1'b0;
        pipe_we  = 1'b0;
        chk("drain.full", 64'(md_ready), 64'h0);
        tick();
        chk_wr("drain.pop20", 1'b1, 5'd20, 32'hE0);
        chk("drain.busy", 64'(busy), 64'h10);
        reset = 1'b0;
        tick();
        chk_wr("drain.rst", 1'b0, 5'd0, 32'h0);
        chk("drain.rst_busy", 64'(busy), 64'h0);
        chk("drain.rst_ready", 64'(md_ready), 64'h1);
        reset = 1'b1;
        tick();
        chk("drain.after1", 64'(regwrite), 64'h0);
        chk("drain.stall", 64'(pipe_stall), 64'h0);
        tick();
        chk_wr("drain.after2", 1'b0, 5'd0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
